accum_warp_looper_bank_split: RTL and testbench

Bank-conflict splitter directly downstream of the accumulation warp looper's vector address stage. It accepts one vector of VSIZE lane addresses plus a lane-valid mask per handshake. It then emits one or more conflict-free beats toward the VSIZE-bank SRAM, each beat carrying at most one lane per bank. The `retire` flag of the vector is forwarded on the final beat only.

---
 rtl/accum_warp_looper_bank_split_if.sv | 52 +++++
 rtl/accum_warp_looper_bank_split.sv | 157 +++++++++++++++
 tb/tb_accum_warp_looper_bank_split.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_warp_looper_bank_split_if.sv
// Handshake and data bundle between the warp looper address stage, the bank
// splitter and the banked SRAM port. The conflict counter signal is present
// only when ACCUM_BANK_SPLIT_STAT_EN is defined.
interface accum_warp_looper_bank_split_if #(
  parameter int unsigned N_CFG = 4,
  parameter int unsigned ABW   = 8,
  parameter int unsigned VSIZE = 4
);
  localparam int unsigned NCFG_BW = $clog2(N_CFG + 1);
  localparam int unsigned CV_BW   = $clog2(VSIZE);

  // Upstream vector side
  logic                                src_rdy;
  logic                                src_ack;
  logic [NCFG_BW-1:0]                  i_id;
  logic [VSIZE-1:0][ABW-1:0]           i_address;
  logic [VSIZE-1:0]                    i_valid;
  logic                                i_retire;

  // Downstream beat side
  logic                                dst_rdy;
  logic                                dst_ack;
  logic [NCFG_BW-1:0]                  o_id;
  logic [VSIZE-1:0][ABW-CV_BW-1:0]     o_bank_addr;
  logic [VSIZE-1:0]                    o_bank_valid;
  logic [VSIZE-1:0][CV_BW-1:0]         o_bank_lane;
  logic                                o_last_beat;
  logic                                o_retire;
`ifdef ACCUM_BANK_SPLIT_STAT_EN
  logic [31:0]                         o_conflict_cnt;
`endif

  // Environment view: drives vectors and beat acks
  modport master (
`ifdef ACCUM_BANK_SPLIT_STAT_EN
    input  o_conflict_cnt,
`endif
    output src_rdy, i_id, i_address, i_valid, i_retire, dst_ack,
    input  src_ack, dst_rdy, o_id, o_bank_addr, o_bank_valid, o_bank_lane, o_last_beat,
    input  o_retire
  );

  // Splitter view
  modport slave (
`ifdef ACCUM_BANK_SPLIT_STAT_EN
    output o_conflict_cnt,
`endif
    input  src_rdy, i_id, i_address, i_valid, i_retire, dst_ack,
    output src_ack, dst_rdy, o_id, o_bank_addr, o_bank_valid, o_bank_lane, o_last_beat,
    output o_retire
  );
endinterface

// File: rtl/accum_warp_looper_bank_split.sv
// Bank-conflict splitter: takes one vector of VSIZE lane addresses and emits
// conflict-free beats, one lane per bank per beat, lowest lane first.
// Optional feature macro: ACCUM_BANK_SPLIT_STAT_EN adds a saturating count of
// non-first beats (o_conflict_cnt).
module accum_warp_looper_bank_split #(
  parameter int unsigned N_CFG = 4,
  parameter int unsigned ABW   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  accum_warp_looper_bank_split_if.slave bus
);
  localparam int unsigned VSIZE   = 4;
  localparam int unsigned CV_BW   = $clog2(VSIZE);
  localparam int unsigned NCFG_BW = $clog2(N_CFG + 1);
  localparam int unsigned RBW     = ABW - CV_BW;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                      state_q, state_d;
  logic [NCFG_BW-1:0]          id_q;
  logic [VSIZE-1:0][ABW-1:0]   addr_q;
  logic                        retire_q;
  logic [VSIZE-1:0]            pending_q, pending_d;

  logic [VSIZE-1:0]            issued;
  logic [VSIZE-1:0]            bank_valid;
  logic [VSIZE-1:0][CV_BW-1:0] bank_lane;
  logic [VSIZE-1:0][RBW-1:0]   bank_addr;
  logic                        last_beat;
  logic                        src_ack;
  logic                        dst_rdy;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a new vector keeps us busy even across the last-beat ack
  always_comb begin
    state_d = state_q;
    if (src_ack) begin
      state_d = StBusy;
    end else if (bus.dst_ack && last_beat) begin
      state_d = StIdle;
    end
  end

  // FSM outputs: handshakes
  always_comb begin
    dst_rdy = (state_q == StBusy);
    src_ack = bus.src_rdy && ((state_q == StIdle) || (bus.dst_ack && last_beat));
  end

  // Beat selection from registers only; descending scan so the lowest lane wins
  always_comb begin
    issued     = '0;
    bank_valid = '0;
    bank_lane  = '0;
    bank_addr  = '0;
    for (int b = 0; b < VSIZE; b++) begin
      for (int i = VSIZE - 1; i >= 0; i--) begin
        if (pending_q[i] && (addr_q[i][CV_BW-1:0] == CV_BW'(b))) begin
          bank_valid[b] = 1'b1;
          bank_lane[b]  = CV_BW'(i);
          bank_addr[b]  = addr_q[i][ABW-1:CV_BW];
        end
      end
    end
    for (int b = 0; b < VSIZE; b++) begin
      if (bank_valid[b]) begin
        issued[bank_lane[b]] = 1'b1;
      end
    end
  end

  assign last_beat = (state_q == StBusy) && ((pending_q & ~issued) == '0);

  // Pending mask: a new vector overrides retirement of the old one's last beat
  always_comb begin
    pending_d = pending_q;
    if (bus.dst_ack && dst_rdy) begin
      pending_d = pending_q & ~issued;
    end
    if (src_ack) begin
      pending_d = bus.i_valid;
    end
  end

  // Holding registers for the accepted vector
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      retire_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (src_ack) begin
        id_q     <= bus.i_id;
        addr_q   <= bus.i_address;
        retire_q <= bus.i_retire;
      end
    end
  end

`ifdef ACCUM_BANK_SPLIT_STAT_EN
  logic        first_q, first_d;
  logic [31:0] cnt_q, cnt_d;

  // Conflict statistics: count acked beats that are not the vector's first
  always_comb begin
    first_d = first_q;
    cnt_d   = cnt_q;
    if (bus.dst_ack && dst_rdy) begin
      first_d = 1'b0;
      if (!first_q && (cnt_q != 32'hffff_ffff)) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    if (src_ack) begin
      first_d = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_conflict_cnt = cnt_q;
`endif

  assign bus.src_ack      = src_ack;
  assign bus.dst_rdy      = dst_rdy;
  assign bus.o_id         = id_q;
  assign bus.o_bank_addr  = bank_addr;
  assign bus.o_bank_valid = bank_valid;
  assign bus.o_bank_lane  = bank_lane;
  assign bus.o_last_beat  = last_beat;
  assign bus.o_retire     = retire_q & last_beat;

  // A beat may only be consumed while one is offered
  dst_ack_needs_rdy_a: assert property (@(posedge i_clk) disable iff (!i_rst)
    bus.dst_ack |-> dst_rdy);

endmodule

// File: tb/tb_accum_warp_looper_bank_split.sv
// Self-checking bench for accum_warp_looper_bank_split (VSIZE=4, ABW=8).
module tb_accum_warp_looper_bank_split;
  localparam int unsigned N_CFG = 4;
  localparam int unsigned ABW   = 8;

  logic clk;
  logic rst_n;

  accum_warp_looper_bank_split_if #(.N_CFG(N_CFG), .ABW(ABW), .VSIZE(4)) bus ();

  accum_warp_looper_bank_split #(.N_CFG(N_CFG), .ABW(ABW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive values for the next cycle
  logic            d_rst;
  logic            d_src_rdy;
  logic            d_ack;
  logic [2:0]      d_id;
  logic [3:0][7:0] d_addr;
  logic [3:0]      d_valid;
  logic            d_retire;

  // Reference model: the current vector plus which beat (k-th per bank) is shown
  bit              m_busy;
  int              m_k;
  int              m_nb;
  logic [3:0][7:0] m_addr;
  logic [3:0]      m_valid;
  logic            m_retire;
  logic [2:0]      m_id;
  longint          m_cnt;
  bit              m_accepted;

  // Beats needed = largest number of valid lanes sharing one bank, at least 1
  function automatic int nbeats(input logic [3:0][7:0] a, input logic [3:0] v);
    int mx;
    int c;
    mx = 1;
    for (int b = 0; b < 4; b++) begin
      c = 0;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && (int'(a[i]) % 4 == b)) c++;
      end
      if (c > mx) mx = c;
    end
    return mx;
  endfunction

  task automatic run_cycle();
    logic            ack;
    logic            exp_src_ack;
    logic            exp_last;
    logic [3:0]      ev;
    logic [3:0][1:0] el;
    logic [3:0][5:0] ea;
    int              c;
    rst_n         = d_rst;
    ack           = d_ack && m_busy && d_rst;
    bus.dst_ack   = ack;
    bus.src_rdy   = d_src_rdy && d_rst;
    bus.i_id      = d_id;
    bus.i_address = d_addr;
    bus.i_valid   = d_valid;
    bus.i_retire  = d_retire;
    ev = '0;
    el = '0;
    ea = '0;
    exp_last    = m_busy && (m_k == m_nb - 1);
    exp_src_ack = d_src_rdy && d_rst && (!m_busy || (ack && exp_last));
    #2;
    if (d_rst) begin
      if (m_busy) begin
        for (int b = 0; b < 4; b++) begin
          c = 0;
          for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && (int'(m_addr[i]) % 4 == b)) begin
              if (c == m_k) begin
                ev[b] = 1'b1;
                el[b] = 2'(i);
                ea[b] = 6'(m_addr[i] / 4);
              end
              c++;
            end
          end
        end
      end
      check("dst_rdy", bus.dst_rdy, m_busy);
      check("src_ack", bus.src_ack, exp_src_ack);
      check("o_id", bus.o_id, m_id);
      check("bank_valid", bus.o_bank_valid, ev);
      check("bank_lane", bus.o_bank_lane, el);
      check("bank_addr", bus.o_bank_addr, ea);
      check("last_beat", bus.o_last_beat, exp_last);
      check("retire", bus.o_retire, m_retire && exp_last);
`ifdef ACCUM_BANK_SPLIT_STAT_EN
      check("conflict_cnt", bus.o_conflict_cnt, m_cnt);
`endif
    end
    @(posedge clk);
    m_accepted = 1'b0;
    if (!d_rst) begin
      m_busy   = 1'b0;
      m_k      = 0;
      m_nb     = 1;
      m_addr   = '0;
      m_valid  = '0;
      m_retire = 1'b0;
      m_id     = '0;
      m_cnt    = 0;
    end else begin
      if (m_busy && ack) begin
        if (m_k > 0 && m_cnt < 64'hffff_ffff) m_cnt++;
        m_k++;
        if (exp_last) m_busy = 1'b0;
      end
      if (exp_src_ack) begin
        m_busy     = 1'b1;
        m_k        = 0;
        m_addr     = d_addr;
        m_valid    = d_valid;
        m_retire   = d_retire;
        m_id       = d_id;
        m_nb       = nbeats(d_addr, d_valid);
        m_accepted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_vec(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] a3, input logic [3:0] v, input logic r,
                         input logic [2:0] id);
    d_addr[0] = a0;
    d_addr[1] = a1;
    d_addr[2] = a2;
    d_addr[3] = a3;
    d_valid   = v;
    d_retire  = r;
    d_id      = id;
  endtask

  // Offer the staged vector until it is taken
  task automatic send();
    int n;
    n = 0;
    d_src_rdy = 1'b1;
    m_accepted = 1'b0;
    while (!m_accepted && n < 40) begin
      run_cycle();
      n++;
    end
    if (!m_accepted) check("send_timeout", 1, 0);
    d_src_rdy = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 40) begin
      run_cycle();
      n++;
    end
    if (m_busy) check("drain_timeout", 1, 0);
  endtask

  initial begin
    d_rst = 1'b0;
    d_src_rdy = 1'b0;
    d_ack = 1'b0;
    set_vec(0, 0, 0, 0, 4'h0, 1'b0, 3'd0);
    m_busy = 1'b0;
    m_k = 0;
    m_nb = 1;
    m_cnt = 0;
    m_id = '0;
    m_retire = 1'b0;
    m_addr = '0;
    m_valid = '0;
    run_cycle();
    run_cycle();
    d_rst = 1'b1;
    run_cycle();

    // One conflict-free beat
    d_ack = 1'b1;
    set_vec(0, 1, 2, 3, 4'hf, 1'b0, 3'd1);
    send();
    drain();

    // Four beats on bank 0
    set_vec(0, 4, 8, 12, 4'hf, 1'b1, 3'd2);
    send();
    drain();
    run_cycle();

    // Empty vector with retire
    set_vec(5, 6, 7, 8, 4'h0, 1'b1, 3'd3);
    send();
    drain();

    // Back-to-back: second vector taken on the first one's last-beat ack
    set_vec(0, 4, 1, 5, 4'hf, 1'b0, 3'd4);
    send();
    set_vec(2, 3, 6, 7, 4'hf, 1'b1, 3'd1);
    send();
    check("b2b_rdy", bus.dst_rdy, 1);
    drain();

    // Stall on beat 1
    d_ack = 1'b0;
    set_vec(1, 5, 2, 3, 4'hf, 1'b0, 3'd2);
    send();
    for (int i = 0; i < 5; i++) run_cycle();
    d_ack = 1'b1;
    drain();

    // Reset during beat 2 of a 4-beat vector
    set_vec(0, 4, 8, 12, 4'hf, 1'b1, 3'd3);
    send();
    run_cycle();
    d_rst = 1'b0;
    run_cycle();
    d_rst = 1'b1;
    check("rst_dst_rdy", bus.dst_rdy, 0);
    check("rst_bank_valid", bus.o_bank_valid, 0);
    run_cycle();
    set_vec(3, 7, 2, 0, 4'hf, 1'b1, 3'd4);
    send();
    drain();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      d_src_rdy = 1'($urandom_range(0, 1));
      d_ack     = ($urandom_range(0, 3) != 0);
      d_rst     = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 4; i++) d_addr[i] = 8'($urandom_range(0, 31));
      d_valid  = 4'($urandom);
      d_retire = 1'($urandom);
      d_id     = 3'($urandom_range(0, 4));
      run_cycle();
    end
    d_rst = 1'b1;
    d_src_rdy = 1'b0;
    d_ack = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
